reg_dump_uart_tx: RTL and testbench

Debug reader for the register file's 176-bit display bus. The bus carries R0..R7, SP, IH and T, with R0 in bits [175:160] and T in bits [15:0]. On a trigger the block snapshots the bus and streams the registers out as UART 8N1 bytes, high byte first, R0 first. It sits beside the register file in the CPU top level and drives the board's serial TX pin, so register state can be inspected while the CPU is frozen or single-stepped.

---
 rtl/reg_dump_uart_tx.sv | 149 ++++++++++++++
 tb/tb_reg_dump_uart_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_uart_tx.sv
// Streams a snapshot of the 176-bit register display bus as UART 8N1 bytes.
// Optional REG_DUMP_HEADER_EN adds a 0xA5 header and an XOR checksum byte.
module reg_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REGS     = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [16*NUM_REGS-1:0] regs_in,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 16 * NUM_REGS;
  localparam int NB = 2 * NUM_REGS;
`ifdef REG_DUMP_HEADER_EN
  localparam logic [4:0] LAST = 5'(NB + 1);
`else
  localparam logic [4:0] LAST = 5'(NB - 1);
`endif
  localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state, state_n;
  logic [15:0]    cnt, cnt_n;
  logic [2:0]     idx, idx_n;
  logic [4:0]     nbyte, nbyte_n;
  logic [W-1:0]   snap, snap_n;
  logic           tx_n, busy_n, done_n;
  logic [7:0]     data [NB];
  logic [7:0]     cur;
  logic           bit_end;

  always_comb begin
    for (int i = 0; i < NB; i++)
      data[i] = snap[W-1-8*i -: 8];
  end

`ifdef REG_DUMP_HEADER_EN
  logic [7:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < NB; i++)
      csum = csum ^ data[i];
  end

  always_comb begin
    if (nbyte == 5'd0)
      cur = 8'hA5;
    else if (nbyte == LAST)
      cur = csum;
    else
      cur = data[nbyte - 5'd1];
  end
`else
  always_comb cur = data[nbyte];
`endif

  assign bit_end = (cnt == BIT_END);

  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + 16'd1;
    idx_n   = idx;
    nbyte_n = nbyte;
    snap_n  = snap;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (start) begin
          snap_n  = regs_in;
          busy_n  = 1'b1;
          state_n = START;
          tx_n    = 1'b0;
          nbyte_n = '0;
          idx_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = cur[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
            tx_n  = cur[3'(idx + 3'd1)];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (nbyte == LAST) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            tx_n    = 1'b1;
          end else begin
            state_n = START;
            tx_n    = 1'b0;
            nbyte_n = nbyte + 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      nbyte <= '0;
      snap  <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      nbyte <= nbyte_n;
      snap  <= snap_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Bench for reg_dump_uart_tx: UART decoder plus byte scoreboard.
// Honours REG_DUMP_HEADER_EN when expecting header/checksum bytes.
module tb_reg_dump_uart_tx;

  localparam int CPB = 4;
`ifdef REG_DUMP_HEADER_EN
  localparam int NBYTES = 24;
`else
  localparam int NBYTES = 22;
`endif
  localparam int LEN = NBYTES * 10 * CPB;

  typedef struct {
    logic [175:0] regs;
    logic [7:0]   csum;
    int           flip;
    int           poke1;
    int           poke2;
  } vec_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic [175:0] regs_in = '0;
  logic         tx, busy, done;

  int checks = 0;
  int errors = 0;
  logic [7:0] q [$];

  reg_dump_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .regs_in(regs_in), .tx(tx), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input longint got,
                       input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // UART receiver sampling mid-bit on negedges
  bit         active = 0;
  int         rc, bi;
  logic [7:0] sh;
  logic [7:0] exp_b;
  always @(negedge CLK) begin
    if (!RST) begin
      active = 0;
    end else if (!active) begin
      if (tx == 1'b0) begin
        active = 1;
        rc = 0;
        bi = 0;
      end
    end else begin
      rc++;
      if (rc == CPB * (bi + 1) + CPB / 2) begin
        if (bi < 8) begin
          sh[bi] = tx;
          bi++;
        end else begin
          active = 0;
          check("stop_bit", tx, 1);
          if (q.size() == 0) begin
            check("unexpected_byte", sh, 9'h100);
          end else begin
            exp_b = q.pop_front();
            check("rx_byte", sh, exp_b);
          end
        end
      end
    end
  end

  task automatic push_exp(input vec_t v);
`ifdef REG_DUMP_HEADER_EN
    q.push_back(8'hA5);
`endif
    for (int k = 0; k < 22; k++)
      q.push_back(v.regs[175-8*k -: 8]);
`ifdef REG_DUMP_HEADER_EN
    q.push_back(v.csum);
`endif
  endtask

  task automatic watch(input vec_t v, input bit pre, input bit chain,
                       input vec_t nxt);
    int n;
    int early;
    n = 0;
    early = 0;
    if (!pre) begin
      regs_in = v.regs;
      push_exp(v);
      start = 1'b1;
    end
    forever begin
      @(negedge CLK);
      start = 1'b0;
      if (!busy) break;
      n++;
      if (done) early++;
      if (n == 1) check("accept_tx_busy", {tx, busy}, 2'b01);
      if (n == v.flip) regs_in = '1;
      if (n == v.poke1 || n == v.poke2) start = 1'b1;
      if (n > LEN + 50) begin
        check("busy_timeout", n, LEN);
        break;
      end
    end
    check("busy_len", n, LEN);
    check("done_early", early, 0);
    check("done_pulse", done, 1);
    if (chain) begin
      regs_in = nxt.regs;
      push_exp(nxt);
      start = 1'b1;
    end else begin
      @(negedge CLK);
      check("done_drop", done, 0);
      check("queue_empty", q.size(), 0);
    end
  endtask

  vec_t vecs [5];
  vec_t va, vb;

  initial begin
    int bad;
    vecs[0] = '{{16'h1234, 144'h0, 16'hBEEF}, 8'h77, 0, 0, 0};
    vecs[1] = '{{16'h1234, 160'h0}, 8'h26, 0, 0, 0};
    vecs[2] = '{{11{16'hA55A}}, 8'hFF, 10, 0, 0};
    vecs[3] = '{{11{16'h0F0F}}, 8'h00, 0, 100, 500};
    vecs[4] = '{176'h0, 8'h00, 10, 0, 0};
    va = '{{16'hCAFE, 144'h0, 16'h0001}, 8'h35, 0, 0, 0};
    vb = vecs[1];

    repeat (5) @(negedge CLK);
    #1 check("reset_outputs", {tx, busy, done}, 3'b100);
    RST = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if ({tx, busy, done} !== 3'b100) bad++;
    end
    check("idle_100", bad, 0);

    for (int i = 0; i < 5; i++)
      watch(vecs[i], 0, 0, vecs[i]);

    // back-to-back: start in the done cycle is accepted
    watch(va, 0, 1, vb);
    watch(vb, 1, 0, vb);

    // reset mid-frame, during byte 1 data bits
    @(negedge CLK);
    regs_in = vecs[0].regs;
    push_exp(vecs[0]);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (44) @(negedge CLK);
    #1 RST = 1'b0;
    #1 check("midreset_outputs", {tx, busy, done}, 3'b100);
    q.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post_reset_idle", {tx, busy}, 2'b10);
    watch(vecs[2], 0, 0, vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
